// File: rtl/seg_scan_driver_8dig.sv
// Time-multiplexed 7-segment scan driver: latches all digits once per frame, then
// drives one active-low anode per refresh slot with BCD decode, leading-zero blanking and dp.
module seg_scan_driver_8dig #(
  parameter int NUM_DIG     = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LEAD  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NUM_DIG-1:0]   digits,
  input  logic [NUM_DIG-1:0]     dig_en,
  input  logic [NUM_DIG-1:0]     dp_in,
  output logic [NUM_DIG-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic                   frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   load_pending;
  logic                   tick;
  logic                   wrap;
  logic                   capture;
  logic [4*NUM_DIG-1:0]   sh_digits;
  logic [NUM_DIG-1:0]     sh_en;
  logic [NUM_DIG-1:0]     sh_dp;
  logic [4*NUM_DIG-1:0]   src_digits;
  logic [NUM_DIG-1:0]     src_en;
  logic [NUM_DIG-1:0]     src_dp;
  logic [NUM_DIG-1:0]     blank_p0;
  logic [3:0]             slot_val_p0;
  logic                   slot_dark_p0;
  logic [NUM_DIG-1:0]     an_p0;
  logic [6:0]             seg_p0;
  logic                   dp_p0;

  // Active-low segments, bit 6 = CG ... bit 0 = CA; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // The first tick after reset loads the shadows and parks the scan at slot 0.
  always_comb begin
    tick       = (cnt == CNT_LAST);
    wrap       = (idx == IDX_LAST);
    capture    = tick && (load_pending || wrap);
    idx_nxt    = (load_pending || wrap) ? '0 : idx + IDX_W'(1);
    src_digits = capture ? digits : sh_digits;
    src_en     = capture ? dig_en : sh_en;
    src_dp     = capture ? dp_in  : sh_dp;
  end

  // Blanking walks down from the top; a disabled digit does not stop it.
  always_comb begin : blank_calc
    logic lead;
    lead     = 1'b1;
    blank_p0 = '0;
    for (int i = NUM_DIG - 1; i > 0; i--) begin
      blank_p0[i] = (BLANK_LEAD != 0) && lead && (src_digits[4*i +: 4] == 4'd0);
      lead        = lead && ((src_digits[4*i +: 4] == 4'd0) || !src_en[i]);
    end
  end

  // Stage p0: decode the slot that becomes visible on the next tick
  always_comb begin
    slot_val_p0  = src_digits[4*idx_nxt +: 4];
    slot_dark_p0 = !src_en[idx_nxt] || blank_p0[idx_nxt];
    an_p0        = '1;
    seg_p0       = 7'h7F;
    dp_p0        = 1'b1;
    if (!slot_dark_p0) begin
      an_p0[idx_nxt] = 1'b0;
      seg_p0         = bcd_to_seg(slot_val_p0);
      dp_p0          = ~src_dp[idx_nxt];
    end
  end

  // Stage p1: registered display outputs, scan state and frame shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      sh_digits    <= '0;
      sh_en        <= '0;
      sh_dp        <= '0;
      an           <= '1;
      seg          <= 7'h7F;
      dp           <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      frame_done <= tick && wrap && !load_pending;
      if (tick) begin
        idx <= idx_nxt;
        an  <= an_p0;
        seg <= seg_p0;
        dp  <= dp_p0;
      end
      if (capture) begin
        sh_digits    <= digits;
        sh_en        <= dig_en;
        sh_dp        <= dp_in;
        load_pending <= 1'b0;
      end
    end
  end

endmodule
